// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution stage.
// Macro CONV_COLLECT_RELU_EN (default off) turns negative stored samples into zero.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

`ifdef CONV_COLLECT_RELU_EN
    localparam bit RELU_EN = 1'b1;
`else
    localparam bit RELU_EN = 1'b0;
`endif

    // Minimum bit width able to index 'value' distinct items (never below 1).
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                width = i + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/conv_frame_collect_ram.sv
// Frame storage for conv_frame_collect: one synchronous write port, one
// synchronous read port, both single-cycle.
module frame_ram #(
    parameter int DEPTH      = 48400,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/conv_frame_collect.sv
// Collects a padded raster stream, crops it to a DxD frame, then replays it
// over valid/ready. Macro CONV_COLLECT_RELU_EN (see conv_pkg) zeroes negatives.
module conv_frame_collect
    import conv_pkg::*;
#(
    parameter int D          = 220,
    parameter int DATA_WIDTH = 32,
    parameter int ROWS_IN    = D + 2,
    parameter int CROP_TOP   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int DD = D * D;
    localparam int AW = clog2(DD);
    localparam int RW = clog2(ROWS_IN);
    localparam int CW = clog2(D);
    localparam int NW = clog2(DD + 1);

    generate
        if (CROP_TOP < 0 || CROP_TOP + D > ROWS_IN) begin : g_bad_crop
            $error("conv_frame_collect: CROP_TOP + D must not exceed ROWS_IN");
        end
    endgenerate

    function automatic logic [DATA_WIDTH-1:0] store_value(input logic [DATA_WIDTH-1:0] sample);
        if (RELU_EN && sample[DATA_WIDTH-1]) begin
            return '0;
        end else begin
            return sample;
        end
    endfunction

    state_e                state_r;
    state_e                next_state_s;
    logic [RW-1:0]         row_r;
    logic [CW-1:0]         col_r;
    logic                  accept_s;
    logic                  drop_s;
    logic                  draining_s;
    logic                  last_in_s;
    logic                  keep_s;
    logic                  wr_en_s;
    logic [AW-1:0]         wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [NW-1:0]         rd_cnt_r;
    logic [AW-1:0]         out_cnt_r;
    logic                  rd_en_s;
    logic                  rd_pend_r;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [DATA_WIDTH-1:0] pxl_out_r;
    logic [DATA_WIDTH-1:0] skid_r;
    logic                  valid_out_r;
    logic                  skid_valid_r;
    logic                  handoff_s;
    logic                  final_handoff_s;
    logic                  out_free_s;
    logic [1:0]            occ_s;
    logic                  busy_r;
    logic                  frame_done_r;
    logic                  overflow_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_state_s = ST_CAPTURE;
                else          next_state_s = ST_IDLE;
            end
            ST_CAPTURE: begin
                if (last_in_s) next_state_s = ST_DRAIN;
                else           next_state_s = ST_CAPTURE;
            end
            ST_DRAIN: begin
                if (final_handoff_s) next_state_s = ST_IDLE;
                else                 next_state_s = ST_DRAIN;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State decode: input is taken in IDLE/CAPTURE and refused during DRAIN.
    always_comb begin
        accept_s   = 1'b0;
        drop_s     = 1'b0;
        draining_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_CAPTURE: accept_s = valid_in;
            ST_DRAIN: begin
                drop_s     = valid_in;
                draining_s = 1'b1;
            end
            default: accept_s = 1'b0;
        endcase
    end

    // Crop compare and write address.
    always_comb begin
        last_in_s = accept_s && (row_r == RW'(ROWS_IN - 1)) && (col_r == CW'(D - 1));
        keep_s    = (int'(row_r) >= CROP_TOP) && (int'(row_r) < CROP_TOP + D);
        wr_en_s   = accept_s && keep_s;
        wr_addr_s = AW'((int'(row_r) - CROP_TOP) * D + int'(col_r));
        wr_data_s = store_value(pxl_in);
    end

    // Raster position of the next input sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_r <= '0;
            col_r <= '0;
        end else if (accept_s) begin
            if (last_in_s) begin
                row_r <= '0;
                col_r <= '0;
            end else if (col_r == CW'(D - 1)) begin
                row_r <= row_r + RW'(1);
                col_r <= '0;
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Reads are issued only while the output register plus skid entry can
    // absorb every sample already in flight.
    always_comb begin
        handoff_s       = valid_out_r && ready_in;
        final_handoff_s = handoff_s && (out_cnt_r == AW'(DD - 1));
        out_free_s      = !valid_out_r || ready_in;
        occ_s           = {1'b0, valid_out_r} + {1'b0, skid_valid_r} + {1'b0, rd_pend_r};
        rd_en_s         = draining_s && (rd_cnt_r < NW'(DD))
                          && ((occ_s - {1'b0, handoff_s}) <= 2'd1);
    end

    // Read-issue and handoff counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_r  <= '0;
            out_cnt_r <= '0;
            rd_pend_r <= 1'b0;
        end else begin
            rd_pend_r <= rd_en_s;
            if (final_handoff_s) begin
                rd_cnt_r  <= '0;
                out_cnt_r <= '0;
            end else begin
                if (rd_en_s)   rd_cnt_r  <= rd_cnt_r + NW'(1);
                if (handoff_s) out_cnt_r <= out_cnt_r + AW'(1);
            end
        end
    end

    // Output register with one-entry skid buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pxl_out_r    <= '0;
            valid_out_r  <= 1'b0;
            skid_r       <= '0;
            skid_valid_r <= 1'b0;
        end else if (out_free_s) begin
            if (skid_valid_r) begin
                pxl_out_r    <= skid_r;
                valid_out_r  <= 1'b1;
                skid_valid_r <= rd_pend_r;
                if (rd_pend_r) skid_r <= rd_data_s;
            end else if (rd_pend_r) begin
                pxl_out_r   <= rd_data_s;
                valid_out_r <= 1'b1;
            end else begin
                valid_out_r <= 1'b0;
            end
        end else if (rd_pend_r) begin
            skid_r       <= rd_data_s;
            skid_valid_r <= 1'b1;
        end
    end

    // Status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            busy_r       <= (next_state_s != ST_IDLE);
            frame_done_r <= final_handoff_s;
            overflow_r   <= overflow_r | drop_s;
        end
    end

    frame_ram #(
        .DEPTH      (DD),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_addr (AW'(rd_cnt_r)),
        .rd_data (rd_data_s)
    );

    assign pxl_out    = pxl_out_r;
    assign valid_out  = valid_out_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign overflow   = overflow_r;

endmodule
